crc_stream_engine: RTL and testbench
====================================

// Module: crc_stream_engine
// PURPOSE
//  Parametrised CRC engine: N data bits per cycle instead of one, runtime poly/init/xorout/reflection.
//  Frames arrive on a valid/ready stream with a last flag. One finalised CRC per frame is returned on
//  an output valid/ready handshake. Sits between packet sources and checkers in place of the serial calculator.
// PARAMETERS
//  CRC_WIDTH   8  CRC register width in bits; legal range 1..64.
//  DATA_WIDTH  8  Bits consumed per accepted beat; legal range 1..64.
// PORTS
//  clk         in   1           Single clock; all logic on rising edge.
//  rst         in   1           Synchronous reset, active-high.
//  cfg_poly    in   CRC_WIDTH   Generator polynomial, implicit top bit, normal (MSB-first) form.
//  cfg_init    in   CRC_WIDTH   Initial register value.
//  cfg_xorout  in   CRC_WIDTH   Final XOR mask.
//  cfg_refin   in   1           1 = bit-reverse each data beat before processing.
//  cfg_refout  in   1           1 = bit-reverse the register before the final XOR.
//  flush       in   1           Synchronous frame abort.
//  s_valid     in   1           Input beat valid.
//  s_ready     out  1           Engine can accept a beat.
//  s_data      in   DATA_WIDTH  Beat data; MSB processed first after any reflection.
//  s_last      in   1           Beat is the final beat of its frame.
//  m_valid     out  1           Finalised CRC available.
//  m_ready     in   1           Consumer accepts the CRC.
//  m_crc       out  CRC_WIDTH   Finalised CRC: (refout ? rev(reg) : reg) ^ xorout.
//  busy        out  1           Frame in progress (state != IDLE).
// BEHAVIOUR
//  Reset: state IDLE, crc_reg=0, cfg latches=0, m_valid=0, m_crc=0, busy=0. s_ready=0 while rst high.
//  A beat is accepted when s_valid && s_ready.
//  FSM states: IDLE, RUN, DONE.
//   IDLE: s_ready=1. On an accepted beat, latch all cfg_* inputs.
//     Compute crc_reg = step(cfg_init, beat) using the live cfg values.
//     Then go to RUN, or go to DONE if s_last is set (a single-beat frame is legal).
//   RUN: s_ready=1. On an accepted beat, crc_reg = step(crc_reg, beat) using the latched cfg.
//     s_last moves to DONE. cfg_* changes during RUN are ignored.
//   DONE: s_ready=0, m_valid=1. m_crc is registered on entry and held stable while m_valid && !m_ready.
//     On m_ready, drop m_valid and go to IDLE. A new frame may start the cycle after the handshake.
//  Latency: m_valid rises on the clock edge after the last beat is accepted. Throughput is one beat
//   per cycle, plus one DONE cycle per frame when m_ready is already high.
//  step(): DATA_WIDTH unrolled iterations of the non-augmented MSB-first update, one cycle.
//   Per bit: fb = reg[CRC_WIDTH-1] ^ d; reg = {reg[CRC_WIDTH-2:0],1'b0} ^ (fb ? poly : 0).
//   When CRC_WIDTH==1, use reg = fb ? poly : 0.
//  No augmentation zeros are required; the result matches standard catalogue check values.
//  flush: highest priority after rst. In any state, go to IDLE next cycle, m_valid=0, crc_reg=0.
//   A beat presented in the same cycle is dropped, and no CRC is produced for the aborted frame.
//  s_valid low mid-frame: a bubble; crc_reg holds.
//  s_valid && s_last while in DONE: the beat is not accepted (s_ready=0) and the source must hold it.
//  rst mid-frame: the frame is discarded and all state returns to reset values.
// STRUCTURE
//  crc_pkg: FSM state typedef (IDLE/RUN/DONE).
//   Also holds preset constants: CRC8 (07/00/00/0/0), CRC16_CCITT_FALSE (1021/FFFF/0000/0/0),
//   CRC32 (04C11DB7/FFFFFFFF/FFFFFFFF/1/1).
//  Sub-module crc_step: combinational, parametrised by CRC_WIDTH/DATA_WIDTH.
//   Ports: crc_in, data, poly, crc_out. Reused by later parallel checkers.
//  Top level holds the FSM, the cfg latches, the reflection muxes and the output register.
// TESTING
//  1 CRC8 preset, W=8/D=8: bytes 31..39 ("123456789"), last on 39, m_ready=1 -> m_crc=F4, m_valid high 1 cycle.
//  2 CRC_WIDTH=16: CCITT_FALSE preset, same 9 bytes -> 29B1.
//    Then a back-to-back second frame in the cycle after the handshake -> 29B1 again.
//  3 CRC_WIDTH=32: CRC32 preset, same bytes with random s_valid bubbles -> CBF43926.
//  4 Backpressure: hold m_ready=0 for 5 cycles after frame 1.
//    -> m_crc stable, s_ready=0 throughout, pending next beat not consumed until the handshake.
//  5 flush after 4 of 9 bytes, then a full 9-byte CRC8 frame -> only one m_valid pulse, value F4.
//  6 Reset mid-frame (rst high 1 cycle) -> m_valid=0, busy=0, s_ready low during rst.
//    A subsequent single-beat frame 00 with CRC8 -> 00.
//    Repeat with init FF, poly 07 -> F3.

Source files
------------

// File: rtl/crc_pkg.sv
// Shared types and catalogue presets for the streaming CRC engine.
package crc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } crc_state_e;

  // Catalogue presets: poly / init / xorout / refin / refout
  localparam logic [7:0]  CRC8_POLY   = 8'h07;
  localparam logic [7:0]  CRC8_INIT   = 8'h00;
  localparam logic [7:0]  CRC8_XOROUT = 8'h00;
  localparam logic        CRC8_REFIN  = 1'b0;
  localparam logic        CRC8_REFOUT = 1'b0;

  localparam logic [15:0] CRC16_CCITT_FALSE_POLY   = 16'h1021;
  localparam logic [15:0] CRC16_CCITT_FALSE_INIT   = 16'hFFFF;
  localparam logic [15:0] CRC16_CCITT_FALSE_XOROUT = 16'h0000;
  localparam logic        CRC16_CCITT_FALSE_REFIN  = 1'b0;
  localparam logic        CRC16_CCITT_FALSE_REFOUT = 1'b0;

  localparam logic [31:0] CRC32_POLY   = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT   = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_XOROUT = 32'hFFFFFFFF;
  localparam logic        CRC32_REFIN  = 1'b1;
  localparam logic        CRC32_REFOUT = 1'b1;

endpackage

// File: rtl/crc_step.sv
// Combinational multi-bit CRC update: DATA_WIDTH MSB-first non-augmented steps in one pass.
module crc_step #(
  parameter int unsigned CRC_WIDTH  = 8,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic [CRC_WIDTH-1:0]  crc_in,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [CRC_WIDTH-1:0]  poly,
  output logic [CRC_WIDTH-1:0]  crc_out
);

  logic [CRC_WIDTH-1:0] r;
  logic                 fb;

  // Left shift also covers the 1-bit register case, where it yields zero.
  always_comb begin
    r  = crc_in;
    fb = 1'b0;
    for (int i = 0; i < int'(DATA_WIDTH); i++) begin
      fb = r[CRC_WIDTH-1] ^ data[DATA_WIDTH-1-i];
      r  = (r << 1) ^ (fb ? poly : '0);
    end
    crc_out = r;
  end

endmodule

// File: rtl/crc_stream_engine.sv
// Streaming CRC engine: one beat per cycle, runtime config latched at frame start, one CRC per frame.
module crc_stream_engine #(
  parameter int unsigned CRC_WIDTH  = 8,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CRC_WIDTH-1:0]  cfg_poly,
  input  logic [CRC_WIDTH-1:0]  cfg_init,
  input  logic [CRC_WIDTH-1:0]  cfg_xorout,
  input  logic                  cfg_refin,
  input  logic                  cfg_refout,
  input  logic                  flush,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [CRC_WIDTH-1:0]  m_crc,
  output logic                  busy
);

  import crc_pkg::*;

  crc_state_e state, state_next;

  logic [CRC_WIDTH-1:0]  crc_reg, poly_q, xorout_q;
  logic                  refin_q, refout_q;

  logic                  in_idle_c, accept_c;
  logic [CRC_WIDTH-1:0]  poly_c, seed_c, xorout_c;
  logic                  refin_c, refout_c;
  logic [DATA_WIDTH-1:0] data_rev_c, beat_c;
  logic [CRC_WIDTH-1:0]  crc_next_c, crc_next_rev_c, crc_final_c;

  // First beat of a frame uses live cfg; later beats use the latched copy.
  assign in_idle_c = (state == ST_IDLE);
  assign accept_c  = s_valid && s_ready && !flush;
  assign poly_c    = in_idle_c ? cfg_poly   : poly_q;
  assign seed_c    = in_idle_c ? cfg_init   : crc_reg;
  assign xorout_c  = in_idle_c ? cfg_xorout : xorout_q;
  assign refin_c   = in_idle_c ? cfg_refin  : refin_q;
  assign refout_c  = in_idle_c ? cfg_refout : refout_q;

  always_comb begin
    data_rev_c = '0;
    for (int i = 0; i < int'(DATA_WIDTH); i++) data_rev_c[i] = s_data[DATA_WIDTH-1-i];
  end

  assign beat_c = refin_c ? data_rev_c : s_data;

  crc_step #(
    .CRC_WIDTH  (CRC_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_step (
    .crc_in  (seed_c),
    .data    (beat_c),
    .poly    (poly_c),
    .crc_out (crc_next_c)
  );

  always_comb begin
    crc_next_rev_c = '0;
    for (int i = 0; i < int'(CRC_WIDTH); i++) crc_next_rev_c[i] = crc_next_c[CRC_WIDTH-1-i];
  end

  assign crc_final_c = (refout_c ? crc_next_rev_c : crc_next_c) ^ xorout_c;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state logic; flush overrides every transition
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_RUN: if (accept_c) state_next = s_last ? ST_DONE : ST_RUN;
      ST_DONE:         if (m_ready)  state_next = ST_IDLE;
      default:         state_next = ST_IDLE;
    endcase
    if (flush) state_next = ST_IDLE;
  end

  // Output decode from the state register
  always_comb begin
    s_ready = 1'b0;
    m_valid = 1'b0;
    busy    = 1'b0;
    s_ready = !rst && (state != ST_DONE);
    m_valid = (state == ST_DONE);
    busy    = (state != ST_IDLE);
  end

  // Datapath: running CRC, config latches, finalised result held through DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      crc_reg  <= '0;
      poly_q   <= '0;
      xorout_q <= '0;
      refin_q  <= 1'b0;
      refout_q <= 1'b0;
      m_crc    <= '0;
    end else if (flush) begin
      crc_reg <= '0;
    end else if (accept_c) begin
      crc_reg <= crc_next_c;
      if (in_idle_c) begin
        poly_q   <= cfg_poly;
        xorout_q <= cfg_xorout;
        refin_q  <= cfg_refin;
        refout_q <= cfg_refout;
      end
      if (s_last) m_crc <= crc_final_c;
    end
  end

endmodule

// File: tb/tb_crc_stream_engine.sv
// Directed bench: three engine widths fed one shared stream, checked against catalogue CRCs.
module tb_crc_stream_engine;
  import crc_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, s_valid, s_last, m_ready;
  logic [7:0]  s_data;

  logic [7:0]  poly8, init8, xor8;
  logic [15:0] poly16, init16, xor16;
  logic [31:0] poly32, init32, xor32;
  logic        refin8, refout8, refin16, refout16, refin32, refout32;

  logic        s_ready8, m_valid8, busy8;
  logic        s_ready16, m_valid16, busy16;
  logic        s_ready32, m_valid32, busy32;
  logic [7:0]  m_crc8;
  logic [15:0] m_crc16;
  logic [31:0] m_crc32;

  crc_stream_engine #(.CRC_WIDTH(8), .DATA_WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .cfg_poly(poly8), .cfg_init(init8), .cfg_xorout(xor8),
    .cfg_refin(refin8), .cfg_refout(refout8), .flush(flush), .s_valid(s_valid),
    .s_ready(s_ready8), .s_data(s_data), .s_last(s_last), .m_valid(m_valid8),
    .m_ready(m_ready), .m_crc(m_crc8), .busy(busy8));

  crc_stream_engine #(.CRC_WIDTH(16), .DATA_WIDTH(8)) u16 (
    .clk(clk), .rst(rst), .cfg_poly(poly16), .cfg_init(init16), .cfg_xorout(xor16),
    .cfg_refin(refin16), .cfg_refout(refout16), .flush(flush), .s_valid(s_valid),
    .s_ready(s_ready16), .s_data(s_data), .s_last(s_last), .m_valid(m_valid16),
    .m_ready(m_ready), .m_crc(m_crc16), .busy(busy16));

  crc_stream_engine #(.CRC_WIDTH(32), .DATA_WIDTH(8)) u32 (
    .clk(clk), .rst(rst), .cfg_poly(poly32), .cfg_init(init32), .cfg_xorout(xor32),
    .cfg_refin(refin32), .cfg_refout(refout32), .flush(flush), .s_valid(s_valid),
    .s_ready(s_ready32), .s_data(s_data), .s_last(s_last), .m_valid(m_valid32),
    .m_ready(m_ready), .m_crc(m_crc32), .busy(busy32));

  int checks   = 0;
  int failures = 0;
  int hs8      = 0;
  int h0;

  logic [7:0] msg [0:8];

  always @(posedge clk) if (m_valid8 && m_ready) hs8 <= hs8 + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_presets();
    poly8  = CRC8_POLY;  init8  = CRC8_INIT;  xor8  = CRC8_XOROUT;
    refin8 = CRC8_REFIN; refout8 = CRC8_REFOUT;
    poly16 = CRC16_CCITT_FALSE_POLY; init16 = CRC16_CCITT_FALSE_INIT;
    xor16  = CRC16_CCITT_FALSE_XOROUT;
    refin16 = CRC16_CCITT_FALSE_REFIN; refout16 = CRC16_CCITT_FALSE_REFOUT;
    poly32 = CRC32_POLY; init32 = CRC32_INIT; xor32 = CRC32_XOROUT;
    refin32 = CRC32_REFIN; refout32 = CRC32_REFOUT;
  endtask

  task automatic scramble_cfg();
    poly8 = 8'hA5; init8 = 8'h3C; xor8 = 8'h55; refin8 = 1'b1; refout8 = 1'b1;
    poly16 = 16'h8005; init16 = 16'h0000; xor16 = 16'hFFFF; refin16 = 1'b1; refout16 = 1'b1;
    poly32 = 32'h1EDC6F41; init32 = 32'h0; xor32 = 32'h0; refin32 = 1'b0; refout32 = 1'b0;
  endtask

  // Present a beat at the falling edge and hold it until a rising edge accepts it.
  task automatic send_beat(input logic [7:0] d, input logic l);
    int n;
    s_valid = 1'b1; s_data = d; s_last = l;
    n = 0;
    while (!s_ready8 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("s_ready_timeout", 64'(s_ready8), 64'd1);
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic send_frame(input bit bubbles, input bit scramble);
    for (int i = 0; i < 9; i++) begin
      send_beat(msg[i], i == 8);
      if (scramble && i == 0) scramble_cfg();
      if (bubbles && i < 8) repeat (i % 3) @(negedge clk);
    end
    if (scramble) set_presets();
  endtask

  task automatic check_result(input string tag);
    check({tag, "_valid8"}, 64'(m_valid8), 64'd1);
    check({tag, "_crc8"},   64'(m_crc8),   64'h0F4);
    check({tag, "_crc16"},  64'(m_crc16),  64'h29B1);
    check({tag, "_crc32"},  64'(m_crc32),  64'hCBF43926);
  endtask

  initial begin
    msg[0] = 8'h31; msg[1] = 8'h32; msg[2] = 8'h33; msg[3] = 8'h34; msg[4] = 8'h35;
    msg[5] = 8'h36; msg[6] = 8'h37; msg[7] = 8'h38; msg[8] = 8'h39;
    rst = 1'b1; flush = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00; m_ready = 1'b1;
    set_presets();

    // Reset state
    @(negedge clk);
    check("rst_s_ready", 64'(s_ready8), 64'd0);
    check("rst_m_valid", 64'(m_valid8), 64'd0);
    check("rst_busy",    64'(busy8),    64'd0);
    check("rst_m_crc",   64'(m_crc8),   64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_s_ready", 64'(s_ready8), 64'd1);

    // Basic frame, m_valid for exactly one cycle
    send_frame(1'b0, 1'b0);
    check_result("t1");
    check("t1_busy_done", 64'(busy8), 64'd1);
    @(negedge clk);
    check("t1_pulse_end", 64'(m_valid8), 64'd0);
    check("t1_idle_busy", 64'(busy8), 64'd0);

    // Back-to-back frames; second frame sees cfg churn after its first beat
    send_frame(1'b0, 1'b0);
    check_result("t2a");
    send_frame(1'b0, 1'b1);
    check_result("t2b");

    // Bubbles between beats
    send_frame(1'b1, 1'b0);
    check_result("t3");

    // Backpressure with the next frame's first beat pending
    @(negedge clk);
    m_ready = 1'b0;
    send_frame(1'b0, 1'b0);
    check_result("t4");
    s_valid = 1'b1; s_data = msg[0]; s_last = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("t4_hold_valid", 64'(m_valid8), 64'd1);
      check("t4_hold_crc",   64'(m_crc8),   64'h0F4);
      check("t4_hold_crc32", 64'(m_crc32),  64'hCBF43926);
      check("t4_s_ready",    64'(s_ready8), 64'd0);
    end
    m_ready = 1'b1;
    send_frame(1'b0, 1'b0);
    check_result("t4b");
    @(negedge clk);

    // Flush mid-frame, then one full frame
    h0 = hs8;
    for (int i = 0; i < 4; i++) send_beat(msg[i], 1'b0);
    flush = 1'b1; s_valid = 1'b1; s_data = msg[4];
    @(negedge clk);
    flush = 1'b0; s_valid = 1'b0;
    check("t5_flush_busy",  64'(busy8),    64'd0);
    check("t5_flush_valid", 64'(m_valid8), 64'd0);
    send_frame(1'b0, 1'b0);
    check_result("t5");
    @(negedge clk);
    check("t5_pulses", 64'(hs8 - h0), 64'd1);

    // Reset mid-frame, then single-beat frames
    for (int i = 0; i < 4; i++) send_beat(msg[i], 1'b0);
    rst = 1'b1;
    #1;
    check("t6_rst_s_ready", 64'(s_ready8), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    check("t6_m_valid", 64'(m_valid8), 64'd0);
    check("t6_busy",    64'(busy8),    64'd0);
    send_beat(8'h00, 1'b1);
    check("t6_single_valid", 64'(m_valid8), 64'd1);
    check("t6_single_00",    64'(m_crc8),   64'h00);
    @(negedge clk);
    init8 = 8'hFF;
    send_beat(8'h00, 1'b1);
    check("t6_init_ff_valid", 64'(m_valid8), 64'd1);
    check("t6_init_ff",       64'(m_crc8),   64'hF3);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
